// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared CPU definitions for hazard detection
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_RSVD = 2'd3
  } md_op_e;

  localparam logic [3:0] MULT_LAT    = 4'd5;
  localparam logic [3:0] DIV_LAT     = 4'd10;
  localparam logic [1:0] TUSE_UNUSED = 2'd3;

  // The reserved encoding behaves exactly like "no operation".
  function automatic logic is_md_start_op(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic [3:0] md_latency(input logic [1:0] op);
    return (op == MD_DIV) ? DIV_LAT : MULT_LAT;
  endfunction

endpackage

// File: rtl/md_tracker.sv
// rtl/md_tracker.sv - HI/LO unit busy tracker driven by the E-stage md op
module md_tracker
  import hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] md_op_E,
  output logic       md_busy
);

  logic [3:0] md_cnt_q;
  logic [3:0] md_cnt_d;

  // Ops arriving while a previous one is in flight are dropped, never reloaded.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end else if (is_md_start_op(md_op_E)) begin
      md_cnt_d = md_latency(md_op_E);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      md_cnt_q <= 4'd0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy = (md_cnt_q != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall control: RAW comparators, HI/LO interlock, stall counter
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  Tuse_rs,
  input  logic [1:0]  Tuse_rt,
  input  logic        md_D,
  input  logic [4:0]  A3_E,
  input  logic [1:0]  Tnew_E,
  input  logic [4:0]  A3_M,
  input  logic [1:0]  Tnew_M,
  input  logic [1:0]  md_op_E,
  output logic        PC_en,
  output logic        IFID_en,
  output logic        IDEX_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  function automatic logic src_hazard(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input logic [4:0] a3,
                                      input logic [1:0] tnew);
    return (src != 5'd0) && (tuse != TUSE_UNUSED) && (src == a3) && (tuse < tnew);
  endfunction

  logic        stall_rs;
  logic        stall_rt;
  logic        stall_md;
  logic        stall;
  logic        stall_out;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  md_tracker u_md_tracker (
    .clk     (clk),
    .reset   (reset),
    .md_op_E (md_op_E),
    .md_busy (md_busy)
  );

  assign stall_rs = src_hazard(rs_D, Tuse_rs, A3_E, Tnew_E) |
                    src_hazard(rs_D, Tuse_rs, A3_M, Tnew_M);
  assign stall_rt = src_hazard(rt_D, Tuse_rt, A3_E, Tnew_E) |
                    src_hazard(rt_D, Tuse_rt, A3_M, Tnew_M);
  assign stall_md = md_D & (md_busy | is_md_start_op(md_op_E));
  assign stall    = stall_rs | stall_rt | stall_md;

  // Reset forces the pipeline to free-run whatever the hazard inputs say.
  assign stall_out = stall & reset;

  assign PC_en    = ~stall_out;
  assign IFID_en  = ~stall_out;
  assign IDEX_clr = stall_out;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, A3_E, A3_M;
  logic [1:0]  Tuse_rs, Tuse_rt, Tnew_E, Tnew_M, md_op_E;
  logic        md_D;
  logic        PC_en, IFID_en, IDEX_clr, md_busy;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  int          cyc       = 0;
  int          busy_last = -1;
  logic [31:0] m_cnt     = 32'd0;
  bit          m_preload = 0;

  hazard_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .rs_D      (rs_D),
    .rt_D      (rt_D),
    .Tuse_rs   (Tuse_rs),
    .Tuse_rt   (Tuse_rt),
    .md_D      (md_D),
    .A3_E      (A3_E),
    .Tnew_E    (Tnew_E),
    .A3_M      (A3_M),
    .Tnew_M    (Tnew_M),
    .md_op_E   (md_op_E),
    .PC_en     (PC_en),
    .IFID_en   (IFID_en),
    .IDEX_clr  (IDEX_clr),
    .md_busy   (md_busy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hz(input int src, input int tuse, input int a3, input int tnew);
    return (src != 0) && (tuse != 3) && (src == a3) && (tuse < tnew);
  endfunction

  function automatic bit m_busy();
    return cyc <= busy_last;
  endfunction

  function automatic bit m_stall();
    bit data, md;
    data = hz(rs_D, Tuse_rs, A3_E, Tnew_E) || hz(rs_D, Tuse_rs, A3_M, Tnew_M) ||
           hz(rt_D, Tuse_rt, A3_E, Tnew_E) || hz(rt_D, Tuse_rt, A3_M, Tnew_M);
    md   = md_D && (m_busy() || md_op_E == 2'd1 || md_op_E == 2'd2);
    return (reset === 1'b1) && (data || md);
  endfunction

  // Reference state advances on the same edge as the DUT.
  always @(posedge clk) begin
    if (reset !== 1'b1) begin
      m_cnt     = 32'd0;
      busy_last = cyc;
    end else begin
      if (m_preload) m_cnt = 32'hFFFF_FFFF;
      if (m_stall()) m_cnt = m_cnt + 32'd1;
      if (!m_busy() && (md_op_E == 2'd1 || md_op_E == 2'd2))
        busy_last = cyc + ((md_op_E == 2'd1) ? 5 : 10);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit es;
      es = m_stall();
      chk("PC_en", PC_en, !es);
      chk("IFID_en", IFID_en, !es);
      chk("IDEX_clr", IDEX_clr, es);
      chk("md_busy", md_busy, m_busy());
      chk("stall_cnt", stall_cnt, m_preload ? 32'hFFFF_FFFF : m_cnt);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_D = 0; rt_D = 0; Tuse_rs = 3; Tuse_rt = 3; md_D = 0;
    A3_E = 0; Tnew_E = 0; A3_M = 0; Tnew_M = 0; md_op_E = 0;
  endtask

  initial begin
    int nb, ns;
    logic [31:0] base;

    clear_inputs();
    reset = 1'b0;
    rs_D = 5; Tuse_rs = 0; A3_E = 5; Tnew_E = 2; md_D = 1; md_op_E = 1;
    next_cycle();
    chk_en = 1;
    #3;
    chk("reset_PC_en", PC_en, 1);
    chk("reset_IDEX_clr", IDEX_clr, 0);
    chk("reset_md_busy", md_busy, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    next_cycle();
    clear_inputs();
    reset = 1'b1;
    next_cycle();

    // Load-use in E
    rs_D = 5; Tuse_rs = 0; A3_E = 5; Tnew_E = 2;
    #3;
    chk("loaduse_PC_en", PC_en, 0);
    chk("loaduse_IFID_en", IFID_en, 0);
    chk("loaduse_IDEX_clr", IDEX_clr, 1);
    next_cycle();
    clear_inputs();
    #3;
    chk("loaduse_stall_cnt", stall_cnt, 1);
    next_cycle();

    // $0 and sufficient Tuse
    rs_D = 0; Tuse_rs = 0; A3_E = 0; Tnew_E = 2;
    #3 chk("zero_reg_no_stall", IDEX_clr, 0);
    next_cycle();
    clear_inputs();
    rt_D = 7; Tuse_rt = 1; A3_M = 7; Tnew_M = 1;
    #3 chk("tuse_eq_tnew_no_stall", IDEX_clr, 0);
    next_cycle();
    Tnew_M = 2;
    #3 chk("rt_m_stall", IDEX_clr, 1);
    next_cycle();
    Tuse_rt = 3; Tnew_M = 3;
    #3 chk("tuse_unused_no_stall", IDEX_clr, 0);
    next_cycle();
    clear_inputs();
    rs_D = 9; Tuse_rs = 1; A3_E = 9; Tnew_E = 2; A3_M = 9; Tnew_M = 2;
    #3 chk("rs_e_and_m_stall", IDEX_clr, 1);
    next_cycle();
    clear_inputs();

    // Reserved md op is not a start
    md_D = 1; md_op_E = 3;
    #3 chk("md_rsvd_no_stall", IDEX_clr, 0);
    next_cycle();
    md_op_E = 0;
    #3 chk("md_rsvd_not_busy", md_busy, 0);
    next_cycle();

    // mult latency with md_D held
    base = m_cnt;
    md_D = 1; md_op_E = 1; nb = 0; ns = 0;
    for (int i = 0; i < 9; i++) begin
      #3;
      nb += int'(md_busy);
      ns += int'(IDEX_clr);
      next_cycle();
      md_op_E = 0;
    end
    chk("mult_busy_cycles", nb, 5);
    chk("mult_stall_cycles", ns, 6);
    #3 chk("mult_stall_cnt_delta", stall_cnt - base, 6);
    next_cycle();
    md_D = 0;

    // div with an ignored restart three cycles later
    md_op_E = 2; nb = 0;
    for (int i = 0; i < 14; i++) begin
      #3;
      nb += int'(md_busy);
      next_cycle();
      md_op_E = (i == 2) ? 2'd1 : 2'd0;
    end
    chk("div_busy_cycles", nb, 10);

    // Reset on the 4th busy cycle of a div
    md_D = 1; md_op_E = 2;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      md_op_E = 0;
    end
    reset = 1'b0;
    #3 chk("reset_mid_div_PC_en", PC_en, 1);
    next_cycle();
    reset = 1'b1;
    #3;
    chk("post_reset_md_busy", md_busy, 0);
    chk("post_reset_stall_cnt", stall_cnt, 0);
    chk("post_reset_PC_en", PC_en, 1);
    next_cycle();
    clear_inputs();

    // Short pseudo-random sweep over small register numbers
    for (int i = 0; i < 60; i++) begin
      rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
      A3_E = 5'($urandom_range(0, 3)); A3_M = 5'($urandom_range(0, 3));
      Tuse_rs = 2'($urandom_range(0, 3)); Tuse_rt = 2'($urandom_range(0, 3));
      Tnew_E = 2'($urandom_range(0, 3)); Tnew_M = 2'($urandom_range(0, 3));
      md_D = 1'($urandom_range(0, 1)); md_op_E = 2'($urandom_range(0, 3));
      next_cycle();
    end
    clear_inputs();
    next_cycle();

    // stall_cnt wrap from 0xFFFFFFFF
    rs_D = 4; Tuse_rs = 0; A3_E = 4; Tnew_E = 1;
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    m_preload = 1;
    #1 release dut.stall_cnt_q;
    #2 chk("preload_stall_cnt", stall_cnt, 32'hFFFF_FFFF);
    next_cycle();
    m_preload = 0;
    #2 chk("wrap_stall_cnt", stall_cnt, 0);
    next_cycle();
    clear_inputs();
    next_cycle();

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
